// File: rtl/fsic_io_serdes_tx.sv
// FSIC IO SERDES lane transmitter: word FIFO feeding an LSB-first shifter,
// one bit per ioclk, with idle (zero) words inserted when the FIFO runs dry.
module fsic_io_serdes_tx #(
    parameter int pCLK_RATIO    = 4,
    parameter int pTxFIFO_DEPTH = 4
) (
    input  logic                  ioclk,
    input  logic                  axis_rst_n,
    input  logic                  txen,
    input  logic [pCLK_RATIO-1:0] txdata_in,
    input  logic                  txdata_in_valid,
    output logic                  txdata_in_ready,
    output logic                  Serial_Data_out,
    output logic                  tx_word_start,
    output logic                  tx_busy,
    output logic [15:0]           tx_underrun_cnt
);

    // state | meaning
    // IDLE  | lane off, pin held low
    // RUN   | loading a word every pCLK_RATIO cycles (data or idle)
    // DRAIN | txen dropped mid-word, finishing the current word
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam int PW = (pCLK_RATIO > 1) ? $clog2(pCLK_RATIO) : 1;
    localparam int AW = $clog2(pTxFIFO_DEPTH);
    localparam int CW = AW + 1;

    state_t                  r_state, w_state_nxt;
    logic [PW-1:0]           r_phase, w_phase_nxt, w_phase_inc;
    logic [pCLK_RATIO-1:0]   r_shreg, w_shreg_nxt;
    logic                    r_ser, w_ser_nxt;
    logic                    r_tws, w_tws_nxt;
    logic [15:0]             r_urun;
    logic                    w_load;

    logic [pCLK_RATIO-1:0]   r_mem [pTxFIFO_DEPTH];
    logic [AW-1:0]           r_wptr, r_rptr;
    logic [CW-1:0]           r_count;
    logic                    w_full, w_empty, w_push, w_pop;
    logic [pCLK_RATIO-1:0]   w_head;

    assign w_full          = (r_count == CW'(pTxFIFO_DEPTH));
    assign w_empty         = (r_count == '0);
    assign w_push          = txdata_in_valid && !w_full;
    assign w_pop           = w_load && !w_empty;
    assign w_head          = r_mem[r_rptr];
    assign w_phase_inc     = (r_phase == PW'(pCLK_RATIO - 1)) ? '0 : r_phase + 1'b1;

    assign txdata_in_ready = !w_full;
    assign Serial_Data_out = r_ser;
    assign tx_word_start   = r_tws;
    assign tx_busy         = (r_state != IDLE);
    assign tx_underrun_cnt = r_urun;

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = '0;
        w_shreg_nxt = r_shreg;
        w_ser_nxt   = 1'b0;
        w_tws_nxt   = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (txen) w_state_nxt = RUN;
            end
            RUN, DRAIN: begin
                if (r_phase == '0) begin
                    if (r_state == RUN && txen) begin
                        // Load sees the pre-edge FIFO; an empty FIFO yields an idle word
                        w_load      = 1'b1;
                        w_shreg_nxt = w_empty ? '0 : w_head;
                        w_ser_nxt   = w_empty ? 1'b0 : w_head[0];
                        w_tws_nxt   = 1'b1;
                        w_phase_nxt = w_phase_inc;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_ser_nxt   = r_shreg[r_phase];
                    w_phase_nxt = w_phase_inc;
                    if (r_state == RUN && !txen)
                        w_state_nxt = DRAIN;
                    else if (r_state == DRAIN && txen)
                        w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ioclk) begin
        if (!axis_rst_n) begin
            r_state <= IDLE;
            r_phase <= '0;
            r_shreg <= '0;
            r_ser   <= 1'b0;
            r_tws   <= 1'b0;
            r_urun  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_shreg <= w_shreg_nxt;
            r_ser   <= w_ser_nxt;
            r_tws   <= w_tws_nxt;
            if (w_load && w_empty && r_urun != 16'hFFFF)
                r_urun <= r_urun + 16'd1;
        end
    end

    always_ff @(posedge ioclk) begin
        if (w_push) r_mem[r_wptr] <= txdata_in;
    end

    always_ff @(posedge ioclk) begin
        if (!axis_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_fsic_io_serdes_tx.sv
// Self-checking bench for fsic_io_serdes_tx: queue-based reference model
// compared every cycle, plus literal expectations from the test plan.
module tb_fsic_io_serdes_tx;
    localparam int R = 4;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       txen = 1'b0;
    logic       valid = 1'b0;
    logic [3:0] data = 4'h0;
    logic       ready, ser, tws, busy;
    logic [15:0] ucnt;

    fsic_io_serdes_tx #(.pCLK_RATIO(R), .pTxFIFO_DEPTH(D)) dut (
        .ioclk(clk), .axis_rst_n(rst_n), .txen(txen),
        .txdata_in(data), .txdata_in_valid(valid), .txdata_in_ready(ready),
        .Serial_Data_out(ser), .tx_word_start(tws), .tx_busy(busy),
        .tx_underrun_cnt(ucnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model: mode 0=off, 1=sending, 2=finishing word after txen drop
    logic [3:0] q[$];
    int         m_mode = 0;
    int         m_pos = 0;
    logic [3:0] m_word = 4'h0;
    int         m_cnt = 0;
    logic       m_ser = 1'b0;
    logic       m_tws = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit do_push;
        if (!rst_n) begin
            q.delete();
            m_mode = 0; m_pos = 0; m_word = 4'h0; m_cnt = 0;
            m_ser = 1'b0; m_tws = 1'b0;
        end else begin
            do_push = valid && (q.size() < D);
            m_ser = 1'b0;
            m_tws = 1'b0;
            if (m_mode == 0) begin
                if (txen) begin m_mode = 1; m_pos = 0; end
            end else if (m_pos == 0) begin
                if (m_mode == 1 && txen) begin
                    if (q.size() > 0) m_word = q.pop_front();
                    else begin
                        m_word = 4'h0;
                        if (m_cnt < 65535) m_cnt++;
                    end
                    m_ser = m_word[0];
                    m_tws = 1'b1;
                    m_pos = 1;
                end else begin
                    m_mode = 0;
                end
            end else begin
                m_ser = m_word[m_pos];
                if (m_mode == 1 && !txen) m_mode = 2;
                else if (m_mode == 2 && txen) m_mode = 1;
                m_pos = (m_pos + 1) % R;
            end
            if (do_push) q.push_back(data);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        chk("serial", {31'd0, ser}, {31'd0, m_ser});
        chk("word_start", {31'd0, tws}, {31'd0, m_tws});
        chk("busy", {31'd0, busy}, (m_mode != 0) ? 32'd1 : 32'd0);
        chk("ready", {31'd0, ready}, (q.size() < D) ? 32'd1 : 32'd0);
        chk("underrun", {16'd0, ucnt}, m_cnt);
    endtask

    task automatic push_word(input logic [3:0] w);
        valid = 1'b1; data = w;
        step();
        valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; txen = 1'b0; valid = 1'b0;
        step(); step();
        rst_n = 1'b1;
    endtask

    logic [7:0]  bits, starts;
    logic [3:0]  nib;
    logic [15:0] cnt_before;

    initial begin
        // Reset values and preloaded A,3 stream
        do_reset();
        chk("rst_serial", {31'd0, ser}, 32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cnt", {16'd0, ucnt}, 32'd0);
        push_word(4'hA);
        push_word(4'h3);
        txen = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            step();
            bits[i] = ser; starts[i] = tws;
        end
        chk("A3_bits", {24'd0, bits}, 32'h3A);
        chk("A3_starts", {24'd0, starts}, 32'h11);
        chk("A3_cnt", {16'd0, ucnt}, 32'd0);
        txen = 1'b0;
        step(); step();

        // Three idle slots from an empty FIFO
        do_reset();
        txen = 1'b1;
        step();
        bits = 8'h00; starts = 8'h00;
        for (int i = 0; i < 12; i++) begin
            step();
            bits[0] = bits[0] | ser;
            if (i % 4 == 0) starts[0] = tws;
            else starts[1] = starts[1] | tws;
        end
        chk("idle_bits", {31'd0, bits[0]}, 32'd0);
        chk("idle_start", {30'd0, starts[1:0]}, 32'd1);
        chk("idle_cnt", {16'd0, ucnt}, 32'd3);
        txen = 1'b0;
        step();
        chk("idle_cnt_hold", {16'd0, ucnt}, 32'd3);

        // txen dropped at phase 2 while sending F; 5 retained
        push_word(4'hF);
        push_word(4'h5);
        txen = 1'b1;
        step();
        step(); nib[0] = ser;
        step(); nib[1] = ser;
        txen = 1'b0;
        step(); nib[2] = ser;
        step(); nib[3] = ser;
        chk("drain_busy_last_bit", {31'd0, busy}, 32'd1);
        step();
        chk("drain_bits", {28'd0, nib}, 32'hF);
        chk("drain_busy", {31'd0, busy}, 32'd0);
        txen = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin step(); nib[i] = ser; end
        chk("retained_5", {28'd0, nib}, 32'h5);

        // Push on the same edge as a load with empty FIFO
        cnt_before = ucnt;
        valid = 1'b1; data = 4'h5;
        step();
        valid = 1'b0;
        chk("sim_idle_start", {31'd0, tws}, 32'd1);
        chk("sim_idle_ser", {31'd0, ser}, 32'd0);
        chk("sim_cnt", {16'd0, ucnt}, {16'd0, cnt_before + 16'd1});
        step(); step(); step();
        for (int i = 0; i < 4; i++) begin step(); nib[i] = ser; end
        chk("sim_next_5", {28'd0, nib}, 32'h5);
        txen = 1'b0;
        for (int i = 0; i < 5; i++) step();

        // Fill FIFO, hold a 5th word, then drain in order
        push_word(4'h1); push_word(4'h2); push_word(4'h4); push_word(4'h8);
        chk("full_ready", {31'd0, ready}, 32'd0);
        push_word(4'h9);
        chk("full_hold_ready", {31'd0, ready}, 32'd0);
        txen = 1'b1;
        step();
        chk("full_ready_e0", {31'd0, ready}, 32'd0);
        step();
        chk("ready_after_pop", {31'd0, ready}, 32'd1);
        for (int i = 0; i < 15; i++) step();
        txen = 1'b0;
        for (int i = 0; i < 5; i++) step();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) txen = ~txen;
            valid = ($urandom_range(0, 2) == 0);
            data  = 4'($urandom_range(0, 15));
            rst_n = ($urandom_range(0, 499) != 0);
            step();
        end
        rst_n = 1'b1; valid = 1'b0;

        // Reset mid-word with words buffered
        do_reset();
        push_word(4'h7); push_word(4'hC); push_word(4'h6);
        txen = 1'b1;
        step(); step(); step();
        rst_n = 1'b0;
        step();
        chk("mid_rst_ser", {31'd0, ser}, 32'd0);
        chk("mid_rst_tws", {31'd0, tws}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_ready", {31'd0, ready}, 32'd1);
        chk("mid_rst_cnt", {16'd0, ucnt}, 32'd0);
        rst_n = 1'b1;
        step();
        step();
        chk("post_rst_empty", {16'd0, ucnt}, 32'd1);
        chk("post_rst_ser", {31'd0, ser}, 32'd0);
        txen = 1'b0;
        for (int i = 0; i < 5; i++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/fsic_io_serdes_tx.md
# fsic_io_serdes_tx

Parallel-to-serial transmitter for the FSIC IO SERDES lane. It is the transmit counterpart of the lane receiver. It accepts pCLK_RATIO-bit words from the core-side logic through a valid/ready handshake and buffers them in a small word FIFO. It then shifts each word out LSB first, one bit per ioclk, so the far-end receiver reassembles bit 0 first. When the FIFO runs dry, idle (all-zero) words are inserted so the lane never stalls mid-stream.

## Interface
- pCLK_RATIO, 4, bits per word; ioclk cycles per word.
- pTxFIFO_DEPTH, 4, word FIFO depth; power of two, ≥2.
- ioclk  input  1  sole clock; all logic on posedge.
- axis_rst_n  input  1  synchronous, active-low reset.
- txen  input  1  lane enable.
- txdata_in  input  pCLK_RATIO  word to send; bit 0 is transmitted first.
- txdata_in_valid  input  1  word valid.
- txdata_in_ready  output  1  = !fifo_full (combinational).
- Serial_Data_out  output  1  registered serial bit.
- tx_word_start  output  1  registered; 1 while Serial_Data_out carries bit 0 of a word.
- tx_busy  output  1  state != IDLE.
- tx_underrun_cnt  output  16  saturating count of idle words inserted while in RUN.

## Operation
- FIFO
  - A push occurs on an edge where valid && ready.
  - A pop occurs only at a word load.
  - Read/write pointers are clog2(pTxFIFO_DEPTH) bits wide, plus an occupancy count of 0..pTxFIFO_DEPTH.
  - A push and a pop on the same edge leave the count unchanged.
  - The FIFO is not flushed by txen=0; only reset clears it.
- phase_cnt
  - Width is clog2(pCLK_RATIO) bits.
  - It increments every edge in RUN or DRAIN and wraps from pCLK_RATIO-1 to 0.
  - It is held at 0 in IDLE.
- States
  - IDLE
    - Serial_Data_out <= 0.
    - txen=1 → RUN, with phase_cnt=0. No bit is emitted on that edge.
  - RUN, phase_cnt==0, txen=1: load edge.
    - If the FIFO is non-empty: shreg <= head, pop, Serial_Data_out <= head[0], tx_word_start <= 1.
    - If the FIFO is empty: shreg <= 0, Serial_Data_out <= 0, tx_word_start <= 1, tx_underrun_cnt += 1, saturating at 16'hFFFF.
  - RUN, phase_cnt==0, txen=0 → IDLE. No load occurs, and Serial_Data_out <= 0.
  - RUN or DRAIN, phase_cnt=k≠0
    - Serial_Data_out <= shreg[k], tx_word_start <= 0.
    - In RUN with txen=0 → DRAIN.
    - In DRAIN with txen=1 → RUN.
  - DRAIN, phase_cnt==0 → IDLE, Serial_Data_out <= 0. Words are never truncated.
- Simultaneous push and load into an empty FIFO: the load sees the pre-edge FIFO, so an idle word is sent and underrun is counted. The pushed word goes out in the next slot.
- Push while full: ready=0, so no push occurs and the upstream holds its data.

## Timing
- Reset (axis_rst_n=0 at a posedge) sets:
  - state=IDLE, phase_cnt=0, FIFO empty, shreg=0.
  - Serial_Data_out=0, tx_word_start=0, tx_underrun_cnt=0, tx_busy=0.
  - txdata_in_ready=1 from the first reset edge onward.
- Reset mid-word aborts the word immediately. Buffered words are lost.
- txen first sampled high at edge E0:
  - E0: enters RUN.
  - E1: load; bit 0 is visible after E1.
  - Bit k of the word is visible after E1+k.
  - The next word's bit 0 is visible after E1+pCLK_RATIO.
- Sustained throughput is 1 word per pCLK_RATIO cycles, with no gaps while the FIFO is non-empty.
- Latency from push into an empty FIFO to bit 0 on the pin: 1..pCLK_RATIO edges, depending on phase.
- tx_word_start asserts every pCLK_RATIO cycles while in RUN, for both data and idle words.
- tx_busy drops on the edge entering IDLE.

## Test plan
- Reset, then txen=1 with the FIFO preloaded with 4'hA, 4'h3 → Serial_Data_out sequence 0,1,0,1, 1,1,0,0. tx_word_start=1 on the 1st and 5th bits. tx_underrun_cnt=0 until the FIFO empties.
- Push 4 words with txen=0 → ready=0 after the 4th push. A 5th valid is held with no push. With txen=1, all 4 words go out in order, and ready returns to 1 after the first pop.
- txen=1 with an empty FIFO for 3 word slots → 12 zero bits, tx_word_start every 4 cycles, tx_underrun_cnt=3.
- Drop txen at phase_cnt=2 while sending 4'hF → all 4 ones complete, then IDLE. tx_busy=0 one cycle after the last bit. The remaining FIFO words are retained and sent after txen returns.
- Push 4'h5 on the same edge as a load with an empty FIFO → idle word sent and underrun +1. 4'h5 is sent in the next slot as 1,0,1,0.
- Assert axis_rst_n=0 mid-word with 3 words buffered → next cycle all outputs are 0, ready=1, the FIFO is empty and the counter is 0.
